alu_acc_ctrl: RTL

Sequential command front-end that sits directly upstream of the combinational 4-bit ALU and also captures what it produces. It accepts one command per handshake and drives the ALU operands: A is an internal accumulator and B is the command operand. It registers the ALU result and flags back into the accumulator and returns them on a response handshake. This turns the stateless ALU into a chainable accumulator machine.

---
 rtl/alu_acc_pkg.sv | 23 ++
 rtl/alu_acc_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_acc_pkg.sv
// Shared encodings for the ALU accumulator front-end: command modes, FSM states
// and the bit positions of the {C,Z,N,V} flag nibble.
package alu_acc_pkg;

    typedef enum logic [1:0] {
        ModeExec = 2'b00,
        ModeLoad = 2'b01,
        ModePeek = 2'b10,
        ModeClr  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned FlagC = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagV = 0;

endpackage

// File: rtl/alu_acc_ctrl.sv
// Command front-end for a combinational 4-bit ALU: keeps the accumulator on ALU A,
// drives B/select from the accepted command, captures result and flags back.
module alu_acc_ctrl
    import alu_acc_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_operand,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [3:0]       alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count
);

    state_e             r_state;
    logic [3:0]         r_acc;
    logic [3:0]         r_flags;
    logic [3:0]         r_b;
    logic [3:0]         r_sel;
    logic               r_rsp_valid;
    logic [3:0]         r_rsp_data;
    logic [3:0]         r_rsp_flags;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_count;

    // Gated by rst_n so the handshake stays closed while reset is held.
    assign cmd_ready  = rst_n & ena & (r_state == StIdle);
    assign alu_a      = r_acc;
    assign alu_b      = r_b;
    assign alu_sel    = r_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_flags  = r_rsp_flags;
    assign sticky_ovf = r_sticky;
    assign op_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_acc       <= 4'h0;
            r_flags     <= 4'h0;
            r_b         <= 4'h0;
            r_sel       <= 4'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 4'h0;
            r_rsp_flags <= 4'h0;
            r_sticky    <= 1'b0;
            r_count     <= '0;
        end else if (ena) begin
            unique case (r_state)
                StIdle: begin
                    if (cmd_valid) begin
                        r_b   <= cmd_operand;
                        r_sel <= cmd_op;
                        unique case (cmd_mode)
                            ModeExec: begin
                                r_state <= StExec;
                            end
                            ModeLoad: begin
                                r_acc       <= cmd_operand;
                                r_rsp_data  <= cmd_operand;
                                r_rsp_flags <= r_flags;
                                r_rsp_valid <= 1'b1;
                                r_state     <= StResp;
                            end
                            ModePeek: begin
                                r_rsp_data  <= r_acc;
                                r_rsp_flags <= r_flags;
                                r_rsp_valid <= 1'b1;
                                r_state     <= StResp;
                            end
                            ModeClr: begin
                                r_acc       <= 4'h0;
                                r_flags     <= 4'h0;
                                r_sticky    <= 1'b0;
                                r_count     <= '0;
                                r_rsp_data  <= 4'h0;
                                r_rsp_flags <= 4'h0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= StResp;
                            end
                            default: r_state <= StIdle;
                        endcase
                    end
                end
                StExec: begin
                    r_acc       <= alu_result;
                    r_flags     <= alu_flags;
                    r_sticky    <= r_sticky | alu_flags[FlagV];
                    r_rsp_data  <= alu_result;
                    r_rsp_flags <= alu_flags;
                    r_rsp_valid <= 1'b1;
                    if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_state <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
